// File: rtl/argmax_classifier.sv
// Scans NUM_CLASSES signed scores from a fixed-latency RAM and reports the index and value of the largest.
// Optional ARGMAX_MARGIN_EN adds second-best tracking with margin / low-confidence outputs.
module argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RD_LATENCY  = 2
`ifdef ARGMAX_MARGIN_EN
  ,
  parameter logic signed [31:0] MARGIN_THRESH = 32'sd256
`endif
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               i_start,
  input  logic signed [31:0] i_rd_data,
  output logic        [13:0] o_rd_addr,
  output logic        [3:0]  o_digit,
  output logic signed [31:0] o_max_score,
  output logic               o_busy,
  output logic               o_done
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic        [31:0] o_margin,
  output logic               o_low_conf
`endif
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMPARE, DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         r_best_idx;
  logic [IDX_W-1:0]         w_issue_idx;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [DATA_W-1:0] r_best;
  logic                     r_best_valid;
  logic                     w_take;

  assign w_take      = !r_best_valid || (i_rd_data > r_best);
  assign w_issue_idx = (r_state == IDLE) ? '0 : r_idx + IDX_W'(1);

`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0] r_second;
  logic                     r_second_valid;
  logic [DATA_W:0]          w_diff;
  logic [DATA_W-1:0]        w_margin;

  // best >= second always, so any carry into bit 31 or above means overflow of the 32-bit range
  assign w_diff   = {r_best[DATA_W-1], r_best} - {r_second[DATA_W-1], r_second};
  assign w_margin = (w_diff[DATA_W] || w_diff[DATA_W-1]) ? 32'h7FFF_FFFF : w_diff[DATA_W-1:0];
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = ISSUE;
      ISSUE:   w_next = (RD_LATENCY == 1) ? COMPARE : WAIT;
      WAIT:    if (r_cnt == CNT_W'(1)) w_next = COMPARE;
      COMPARE: w_next = (r_idx == LAST_IDX) ? DONE : ISSUE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Scan datapath and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_best       <= '0;
      r_best_idx   <= '0;
      r_best_valid <= 1'b0;
      o_rd_addr    <= BASE;
      o_digit      <= '0;
      o_max_score  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      r_second       <= '0;
      r_second_valid <= 1'b0;
      o_margin       <= '0;
      o_low_conf     <= 1'b0;
`endif
    end else begin
      o_busy <= (w_next != IDLE);
      o_done <= (r_state == DONE);

      // Address is set on entry to ISSUE and held until the matching COMPARE
      if (w_next == ISSUE)     o_rd_addr <= BASE + ADDR_W'(w_issue_idx);
      else if (w_next == IDLE) o_rd_addr <= BASE;

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_idx        <= '0;
            r_best_valid <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            r_second_valid <= 1'b0;
`endif
          end
        end
        ISSUE: r_cnt <= WAIT_INIT;
        WAIT:  r_cnt <= r_cnt - CNT_W'(1);
        COMPARE: begin
          if (w_take) begin
            r_best       <= i_rd_data;
            r_best_idx   <= r_idx;
            r_best_valid <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
            if (r_best_valid) begin
              r_second       <= r_best;
              r_second_valid <= 1'b1;
            end
          end else if (!r_second_valid || (i_rd_data > r_second)) begin
            r_second       <= i_rd_data;
            r_second_valid <= 1'b1;
`endif
          end
          if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
        end
        DONE: begin
          o_digit     <= r_best_idx;
          o_max_score <= r_best;
`ifdef ARGMAX_MARGIN_EN
          o_margin    <= w_margin;
          o_low_conf  <= ($signed(w_margin) < MARGIN_THRESH);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter NUM_CLASSES, 10, number of scores to scan (2..16).
REQ-002 Parameter BASE_ADDR, 0, temp-RAM address of class 0 score.
REQ-003 Parameter RD_LATENCY, 2, cycles from rd_addr change to valid rd_data (1..4).
REQ-004 Clk  in  1  clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to classify; sampled only in IDLE.
REQ-007 rd_data  in  32  signed score read from temp RAM.
REQ-008 rd_addr  out  14  temp-RAM read address.
REQ-009 digit  out  4  index of winning class.
REQ-010 max_score  out  32  signed score of winning class.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse when digit/max_score are updated.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, COMPARE, DONE.
REQ-014 IDLE -> ISSUE on start; idx cleared to 0, best_valid cleared.
REQ-015 ISSUE: rd_addr = BASE_ADDR + idx; wait counter loaded with RD_LATENCY-1; -> WAIT, or -> COMPARE directly when RD_LATENCY=1.
REQ-016 WAIT: rd_addr held; counter decrements; -> COMPARE when counter reaches 0.
REQ-017 COMPARE: rd_data sampled; replaces best when best_valid=0 or rd_data > best (signed, strict).
REQ-018 Ties: lowest index wins; equal later score never replaces best.
REQ-019 COMPARE: if idx = NUM_CLASSES-1 -> DONE, else idx+1 and -> ISSUE.
REQ-020 rd_addr SHALL remain stable from ISSUE through COMPARE of the same index.
REQ-021 DONE: digit and max_score loaded from best registers; done=1 for exactly this cycle; -> IDLE.
REQ-022 digit/max_score SHALL hold their values from DONE until the next DONE.
REQ-023 start while busy=1 SHALL be ignored, no queuing.
REQ-024 Latency start-to-done SHALL be NUM_CLASSES*(RD_LATENCY+1)+2 cycles (32 for defaults).
REQ-025 All-negative scores SHALL be handled correctly; result is least-negative score.
REQ-026 rd_addr in IDLE SHALL equal BASE_ADDR.

Reset
REQ-027 Reset SHALL force IDLE, idx=0, best_valid=0, digit=0, max_score=0, done=0, busy=0, rd_addr=BASE_ADDR.
REQ-028 Reset mid-scan SHALL abort with no done pulse and outputs cleared per REQ-027.
REQ-029 Reset coincident with start SHALL win; block stays IDLE.

Configuration
REQ-030 Macro ARGMAX_MARGIN_EN SHALL, when defined, add parameter MARGIN_THRESH (default 32'sd256), ports margin out 32 and low_conf out 1, and track second-best score.
REQ-031 With ARGMAX_MARGIN_EN: replaced best becomes second-best; non-winning score > second-best replaces it; margin = best - second computed 33-bit, saturated to 32'h7FFFFFFF.
REQ-032 With ARGMAX_MARGIN_EN: margin and low_conf (margin < MARGIN_THRESH) updated in DONE, held otherwise, cleared to 0 by Reset.
REQ-033 Without ARGMAX_MARGIN_EN: no margin/low_conf ports, no second-best register; all other behaviour identical.

Verification
REQ-034 Scores {0,5,-3,100,7,2,1,0,9,4}, start -> done at cycle 32, digit=3, max_score=100.
REQ-035 Scores all -50 except class 6=-2 -> digit=6, max_score=-2.
REQ-036 Scores class 2=80 and class 7=80, rest 0 -> digit=2 (tie rule); margin=0, low_conf=1 when ARGMAX_MARGIN_EN.
REQ-037 Reset asserted at cycle 10 of a scan -> no done, busy=0 next cycle, digit=0; fresh start then completes normally.
REQ-038 start pulsed again at cycle 5 of scan -> single done at cycle 32, result unaffected.
REQ-039 ARGMAX_MARGIN_EN, class 0=32'sh7FFFFFF0, class 1=32'sh80000000 -> margin=32'h7FFFFFFF, low_conf=0.
